ecc_apb_ctrl: RTL and testbench
===============================

Name: ecc_apb_ctrl

Overview:
APB slave register front-end sitting directly upstream of the ECC encoder/decoder core. It decodes APB writes into the operand registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and issues a one-cycle start to the core. It tracks the busy state and captures the core's result (data, error count) into readable registers. Owns all APB timing so the core sees only stable operands plus a start pulse.

Parameters:
AMBA_WORD, 32, APB data bus width
AMBA_ADDR_WIDTH, 20, APB address bus width
DATA_WIDTH, 32, max codeword/data width driven to core

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
PADDR  in  AMBA_ADDR_WIDTH  APB address
PENABLE  in  1  APB access phase
PSEL  in  1  APB select
PWRITE  in  1  APB write=1/read=0
PWDATA  in  AMBA_WORD  APB write data
PRDATA  out  AMBA_WORD  APB read data, registered
core_start  out  1  one-cycle launch pulse to ECC core
core_op  out  2  0=encode, 1=decode, 2=full channel (encode+noise+decode), 3=reserved
core_data_in  out  DATA_WIDTH  DATA_IN register
core_width  out  2  0=8b, 1=16b, 2=32b codeword, 3=reserved
core_noise  out  DATA_WIDTH  NOISE register
core_done  in  1  one-cycle completion pulse from core
core_data_out  in  DATA_WIDTH  core result, valid with core_done
core_num_of_errors  in  2  0=none, 1=corrected, 2=uncorrectable
busy  out  1  operation in flight

Behaviour:
- Register map (byte address, PADDR[1:0] ignored, all other PADDR bits fully decoded): 0x00 CTRL[1:0] RW; 0x04 DATA_IN RW; 0x08 CODEWORD_WIDTH[1:0] RW; 0x0C NOISE RW; 0x10 RESULT_DATA RO; 0x14 STATUS RO = {busy at bit 31, num_of_errors at [1:0]}, other bits 0.
- Reset (rst low, asynchronous): all registers, PRDATA, core_start, busy = 0. Reset mid-operation aborts tracking; a later core_done while idle is ignored.
- Write commits on the cycle PSEL&PENABLE&PWRITE is high. No PREADY; every transfer has zero wait states.
- Read: in the setup phase (PSEL & !PENABLE & !PWRITE), PRDATA is loaded from the addressed register, so it is valid throughout the access phase. PRDATA holds its value otherwise. Unmapped address reads 0.
- Writes to unmapped or RO addresses are ignored.
- Writes to any RW register while busy=1 are ignored, so operands stay stable for the core.
- A CTRL write with busy=0 and value != 3 updates CTRL, sets busy the next cycle, and pulses core_start for exactly one cycle (the cycle after the write). CTRL=3 is stored but launches nothing.
- CODEWORD_WIDTH=3 is stored. A launch with width 3 is blocked: no start, STATUS.num_of_errors=2.
- core_done with busy=1: RESULT_DATA <= core_data_out, num_of_errors <= core_num_of_errors, busy <= 0, same edge. core_done with busy=0 is ignored.
- If core_done and a CTRL write arrive in the same cycle, the write is ignored because busy is still 1 during that cycle.
- Reading STATUS/RESULT while busy returns the previous result.
- Outputs core_op/data_in/width/noise are direct register outputs (no combinational path from APB).
- FSM: IDLE -> (valid CTRL write) LAUNCH (core_start=1) -> WAIT (busy) -> (core_done) IDLE. busy=1 in LAUNCH and WAIT.

Decomposition:
- Shared package ecc_pkg: op enum (ENCODE, DECODE, FULL_CHANNEL), width enum (W8, W16, W32), register address localparams, ctrl FSM state typedef, error-count encodings.
- One sub-module: ecc_apb_if (APB phase decode producing wr_en/rd_en/reg index). Register storage and FSM stay in the top.

Test Plan:
- Reset then read 0x14 -> PRDATA=0x0000_0000; core_start never pulses.
- Write DATA_IN=0x0000_00A5, WIDTH=0, CTRL=0 -> core_start high exactly one cycle after the CTRL access phase, core_data_in=0xA5, core_op=0, busy=1.
- With busy=1, write DATA_IN=0xFFFF_FFFF -> core_data_in stays 0xA5. Core returns done with data 0x5A, errors=1 -> read 0x10=0x5A, 0x14=0x1, busy=0.
- Drive core_done in the same cycle as a CTRL write -> no new core_start; busy=0 afterward.
- Write to 0x18 and to 0x10 -> no state change; read 0x18 -> 0.
- Assert rst low in WAIT, release, then pulse core_done -> RESULT_DATA and STATUS remain 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and encodings for the ECC APB front-end and the ECC core interface.
package ecc_pkg;

  typedef enum logic [1:0] {
    OP_ENCODE       = 2'd0,
    OP_DECODE       = 2'd1,
    OP_FULL_CHANNEL = 2'd2
  } op_e;
  localparam logic [1:0] OP_RESERVED = 2'd3;

  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2
  } width_e;
  localparam logic [1:0] WIDTH_RESERVED = 2'd3;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_CORRECTED = 2'd1;
  localparam logic [1:0] ERR_UNCORR    = 2'd2;

  // Word index of each register (byte address >> 2)
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_DATA_IN = 3'd1;
  localparam logic [2:0] REG_WIDTH   = 3'd2;
  localparam logic [2:0] REG_NOISE   = 3'd3;
  localparam logic [2:0] REG_RESULT  = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  typedef logic [1:0] ctrl_state_t;
  localparam ctrl_state_t ST_IDLE   = 2'd0;
  localparam ctrl_state_t ST_LAUNCH = 2'd1;
  localparam ctrl_state_t ST_WAIT   = 2'd2;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       hit;
    logic [2:0] idx;
  } apb_dec_t;

endpackage

// File: rtl/ecc_apb_if.sv
// APB phase decode: write strobe in the access phase, read strobe in the setup phase,
// and a fully decoded register index.
module ecc_apb_if
  import ecc_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic                       pwrite_i,
  input  logic [AMBA_ADDR_WIDTH-1:0] paddr_i,
  output apb_dec_t                   dec_o
);

  logic [AMBA_ADDR_WIDTH-3:0] word_addr;
  logic [1:0]                 unused_byte_lane;

  assign word_addr        = paddr_i[AMBA_ADDR_WIDTH-1:2];
  assign unused_byte_lane = paddr_i[1:0];

  always_comb begin
    dec_o     = '0;
    dec_o.wr  = psel_i & penable_i & pwrite_i;
    dec_o.rd  = psel_i & ~penable_i & ~pwrite_i;
    // Any set bit above the register window makes the access unmapped
    dec_o.hit = (word_addr <= (AMBA_ADDR_WIDTH-2)'(REG_STATUS));
    dec_o.idx = word_addr[2:0];
  end

endmodule

// File: rtl/ecc_apb_ctrl.sv
// APB register front-end for the ECC core: operand registers, launch/busy FSM,
// and result capture.
module ecc_apb_ctrl
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       core_start,
  output logic [1:0]                 core_op,
  output logic [DATA_WIDTH-1:0]      core_data_in,
  output logic [1:0]                 core_width,
  output logic [DATA_WIDTH-1:0]      core_noise,
  input  logic                       core_done,
  input  logic [DATA_WIDTH-1:0]      core_data_out,
  input  logic [1:0]                 core_num_of_errors,
  output logic                       busy
);

  apb_dec_t dec;

  ecc_apb_if #(.AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH)) u_apb_if (
    .psel_i    (PSEL),
    .penable_i (PENABLE),
    .pwrite_i  (PWRITE),
    .paddr_i   (PADDR),
    .dec_o     (dec)
  );

  logic [1:0]            ctrl_q, ctrl_d, width_q, width_d, nerr_q, nerr_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d, noise_q, noise_d, result_q, result_d;
  logic [AMBA_WORD-1:0]  prdata_q, prdata_d, rd_mux;
  ctrl_state_t           state_q, state_d;
  logic                  busy_w, wr_ok, done_ok;

  assign busy_w  = (state_q != ST_IDLE);
  // Operands are frozen while the core owns them
  assign wr_ok   = dec.wr & dec.hit & ~busy_w;
  assign done_ok = core_done & busy_w;

  always_comb begin
    ctrl_d    = ctrl_q;
    width_d   = width_q;
    nerr_d    = nerr_q;
    data_in_d = data_in_q;
    noise_d   = noise_q;
    result_d  = result_q;
    state_d   = state_q;
    if (state_q == ST_LAUNCH) state_d = ST_WAIT;
    if (wr_ok) begin
      case (dec.idx)
        REG_CTRL: begin
          ctrl_d = PWDATA[1:0];
          if (PWDATA[1:0] != OP_RESERVED) begin
            if (width_q == WIDTH_RESERVED) nerr_d  = ERR_UNCORR;
            else                           state_d = ST_LAUNCH;
          end
        end
        REG_DATA_IN: data_in_d = PWDATA[DATA_WIDTH-1:0];
        REG_WIDTH:   width_d   = PWDATA[1:0];
        REG_NOISE:   noise_d   = PWDATA[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
    if (done_ok) begin
      result_d = core_data_out;
      nerr_d   = core_num_of_errors;
      state_d  = ST_IDLE;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (dec.hit) begin
      case (dec.idx)
        REG_CTRL:    rd_mux = AMBA_WORD'(ctrl_q);
        REG_DATA_IN: rd_mux = AMBA_WORD'(data_in_q);
        REG_WIDTH:   rd_mux = AMBA_WORD'(width_q);
        REG_NOISE:   rd_mux = AMBA_WORD'(noise_q);
        REG_RESULT:  rd_mux = AMBA_WORD'(result_q);
        REG_STATUS: begin
          rd_mux[AMBA_WORD-1] = busy_w;
          rd_mux[1:0]         = nerr_q;
        end
        default: ;
      endcase
    end
    prdata_d = dec.rd ? rd_mux : prdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      width_q   <= '0;
      nerr_q    <= '0;
      data_in_q <= '0;
      noise_q   <= '0;
      result_q  <= '0;
      prdata_q  <= '0;
      state_q   <= ST_IDLE;
    end else begin
      ctrl_q    <= ctrl_d;
      width_q   <= width_d;
      nerr_q    <= nerr_d;
      data_in_q <= data_in_d;
      noise_q   <= noise_d;
      result_q  <= result_d;
      prdata_q  <= prdata_d;
      state_q   <= state_d;
    end
  end

  assign PRDATA       = prdata_q;
  assign core_start   = (state_q == ST_LAUNCH);
  assign busy         = busy_w;
  assign core_op      = ctrl_q;
  assign core_data_in = data_in_q;
  assign core_width   = width_q;
  assign core_noise   = noise_q;

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Self-checking bench for ecc_apb_ctrl: register-map vector table plus launch,
// busy-lockout, collision, reserved-value and reset-abort sequences.
module tb_ecc_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] PADDR = '0;
  logic        PENABLE = 1'b0, PSEL = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        core_start, busy;
  logic [1:0]  core_op, core_width;
  logic [31:0] core_data_in, core_noise;
  logic        core_done = 1'b0;
  logic [31:0] core_data_out = '0;
  logic [1:0]  core_num_of_errors = '0;

  ecc_apb_ctrl dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .core_start(core_start),
    .core_op(core_op), .core_data_in(core_data_in), .core_width(core_width),
    .core_noise(core_noise), .core_done(core_done), .core_data_out(core_data_out),
    .core_num_of_errors(core_num_of_errors), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always @(posedge clk) if (core_start) start_cnt++;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
    @(posedge clk) #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk) #1;
    PENABLE = 1'b1;
    @(posedge clk) #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    e.exp = exp; e.nm = nm;
    sb_q.push_back(e);
    @(posedge clk) #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk) #1;
    PENABLE = 1'b1;
    e = sb_q.pop_front();
    chk(e.nm, PRDATA, e.exp);
    @(posedge clk) #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_done(input logic [31:0] d, input logic [1:0] ne);
    @(posedge clk) #1;
    core_done = 1'b1; core_data_out = d; core_num_of_errors = ne;
    @(posedge clk) #1;
    core_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int starts;
    tbl.push_back('{0, 20'h00014, 32'h0, 32'h0000_0000, "rst_status"});
    tbl.push_back('{0, 20'h00000, 32'h0, 32'h0000_0000, "rst_ctrl"});
    tbl.push_back('{0, 20'h00010, 32'h0, 32'h0000_0000, "rst_result"});
    tbl.push_back('{1, 20'h0000C, 32'hDEAD_BEEF, 32'h0, "wr_noise"});
    tbl.push_back('{0, 20'h0000C, 32'h0, 32'hDEAD_BEEF, "rd_noise"});
    tbl.push_back('{1, 20'h00008, 32'hFFFF_FFFE, 32'h0, "wr_width"});
    tbl.push_back('{0, 20'h00008, 32'h0, 32'h0000_0002, "rd_width_masked"});
    tbl.push_back('{1, 20'h00008, 32'h0, 32'h0, "wr_width0"});
    tbl.push_back('{1, 20'h00018, 32'h1234_5678, 32'h0, "wr_unmapped"});
    tbl.push_back('{0, 20'h00018, 32'h0, 32'h0000_0000, "rd_unmapped"});
    tbl.push_back('{1, 20'h00010, 32'h0000_FFFF, 32'h0, "wr_result_ro"});
    tbl.push_back('{0, 20'h00010, 32'h0, 32'h0000_0000, "rd_result_ro"});
    tbl.push_back('{1, 20'h00014, 32'hFFFF_FFFF, 32'h0, "wr_status_ro"});
    tbl.push_back('{0, 20'h00014, 32'h0, 32'h0000_0000, "rd_status_ro"});
    tbl.push_back('{0, 20'h8000C, 32'h0, 32'h0000_0000, "rd_alias_high"});
    tbl.push_back('{0, 20'h0000F, 32'h0, 32'hDEAD_BEEF, "rd_byte_lane"});
    tbl.push_back('{1, 20'h00004, 32'h0000_00A5, 32'h0, "wr_data_in"});
    tbl.push_back('{0, 20'h00004, 32'h0, 32'h0000_00A5, "rd_data_in"});
    tbl.push_back('{0, 20'h00008, 32'h0, 32'h0000_0000, "rd_width0"});

    cyc(3);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    cyc(2);

    foreach (tbl[i]) begin
      if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
      else           apb_read(tbl[i].addr, tbl[i].exp, tbl[i].nm);
    end
    chk("noise_out", core_noise, 32'hDEAD_BEEF);
    chk("no_start_yet", start_cnt, 0);

    // Encode launch: start pulses exactly one cycle after the CTRL access phase
    apb_write(20'h00000, 32'h0);
    chk("launch_start", {31'b0, core_start}, 32'h1);
    chk("launch_busy", {31'b0, busy}, 32'h1);
    chk("launch_op", {30'b0, core_op}, 32'h0);
    chk("launch_data", core_data_in, 32'h0000_00A5);
    cyc(1);
    chk("start_one_cycle", {31'b0, core_start}, 32'h0);
    chk("wait_busy", {31'b0, busy}, 32'h1);

    apb_write(20'h00004, 32'hFFFF_FFFF);
    chk("busy_wr_locked", core_data_in, 32'h0000_00A5);
    apb_read(20'h00014, 32'h8000_0000, "status_busy");
    apb_read(20'h00010, 32'h0000_0000, "result_busy_prev");
    pulse_done(32'h0000_005A, 2'd1);
    chk("done_busy", {31'b0, busy}, 32'h0);
    apb_read(20'h00010, 32'h0000_005A, "result_5a");
    apb_read(20'h00014, 32'h0000_0001, "status_corr");
    chk("start_count1", start_cnt, 1);

    // Decode launch, then core_done collides with a CTRL write
    apb_write(20'h00000, 32'h1);
    chk("dec_op", {30'b0, core_op}, 32'h1);
    cyc(2);
    @(posedge clk) #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h0; PWDATA = 32'h2;
    @(posedge clk) #1;
    PENABLE = 1'b1; core_done = 1'b1; core_data_out = 32'h33; core_num_of_errors = 2'd0;
    @(posedge clk) #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; core_done = 1'b0;
    chk("collide_nostart", {31'b0, core_start}, 32'h0);
    chk("collide_idle", {31'b0, busy}, 32'h0);
    cyc(2);
    chk("start_count2", start_cnt, 2);
    apb_read(20'h00000, 32'h0000_0001, "collide_ctrl_kept");
    apb_read(20'h00010, 32'h0000_0033, "collide_result");

    // Reserved op: stored, no launch
    starts = start_cnt;
    apb_write(20'h00000, 32'h3);
    cyc(2);
    chk("op3_nostart", start_cnt, starts);
    chk("op3_idle", {31'b0, busy}, 32'h0);
    apb_read(20'h00000, 32'h0000_0003, "op3_stored");

    // Reserved width blocks the launch and flags uncorrectable
    apb_write(20'h00008, 32'h3);
    apb_write(20'h00000, 32'h2);
    cyc(2);
    chk("w3_nostart", start_cnt, starts);
    chk("w3_idle", {31'b0, busy}, 32'h0);
    apb_read(20'h00014, 32'h0000_0002, "w3_status");
    apb_write(20'h00008, 32'h2);
    chk("width_out", {30'b0, core_width}, 32'h2);

    // Reset while waiting, then a stray done must be ignored
    apb_write(20'h00000, 32'h2);
    chk("full_start", {31'b0, core_start}, 32'h1);
    cyc(2);
    rst = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_data", core_data_in, 32'h0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    pulse_done(32'h0000_0077, 2'd1);
    chk("stray_done_idle", {31'b0, busy}, 32'h0);
    apb_read(20'h00010, 32'h0000_0000, "stray_result");
    apb_read(20'h00014, 32'h0000_0000, "stray_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
